// File: rtl/can_pkg.sv
// Shared CAN definitions: FSM states, field widths, error codes and the CRC-15 step.
package can_pkg;

  localparam logic [14:0] CAN_CRC_POLY = 15'h4599;

  localparam int CAN_ID_W   = 11;
  localparam int CAN_DLC_W  = 4;
  localparam int CAN_CRC_W  = 15;
  localparam int CAN_EOF_W  = 7;
  localparam int CAN_IDLE_W = 11;

  typedef enum logic [3:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_ID,
    ST_RTR,
    ST_IDE,
    ST_R0,
    ST_DLC,
    ST_DATA,
    ST_CRC,
    ST_CRC_DEL,
    ST_ACK_SLOT,
    ST_ACK_DEL,
    ST_EOF
  } can_state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_STUFF = 2'd1,
    ERR_CRC   = 2'd2,
    ERR_FORM  = 2'd3
  } can_err_e;

  function automatic logic [CAN_CRC_W-1:0] crc15_step(input logic [CAN_CRC_W-1:0] crc,
                                                      input logic b);
    logic fb;
    fb = b ^ crc[CAN_CRC_W-1];
    return {crc[CAN_CRC_W-2:0], 1'b0} ^ (fb ? CAN_CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/can_rx_if.sv
// Bus pins and received-frame outputs of the CAN receiver; slave is the receiver side.
interface can_rx_if;
  logic        CAN_RX;
  logic        CAN_TX;
  logic [10:0] rx_id;
  logic        rx_rtr;
  logic [3:0]  rx_dlc;
  logic [63:0] rx_data;
  logic        rx_valid;
  logic        rx_error;
  logic [1:0]  err_code;

  modport slave (
    input  CAN_RX,
    output CAN_TX, rx_id, rx_rtr, rx_dlc, rx_data, rx_valid, rx_error, err_code
  );

  modport master (
    output CAN_RX,
    input  CAN_TX, rx_id, rx_rtr, rx_dlc, rx_data, rx_valid, rx_error, err_code
  );
endinterface

// File: rtl/can_crc15.sv
// Serial CAN CRC-15; clear has priority and may coincide with the first shifted bit.
module can_crc15
  import can_pkg::*;
(
  input  logic                 clk,
  input  logic                 RESET,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic                 bit_i,
  output logic [CAN_CRC_W-1:0] crc_o
);

  logic [CAN_CRC_W-1:0] crc_q;
  logic [CAN_CRC_W-1:0] base;

  always_comb base = clr_i ? '0 : crc_q;

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      crc_q <= '0;
    end else if (clr_i || en_i) begin
      crc_q <= en_i ? crc15_step(base, bit_i) : base;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/can_rx.sv
// CAN 2.0A standard-frame receiver: destuffs, checks CRC and form, drives ACK,
// and presents frames whose identifier matches the acceptance address.
module can_rx
  import can_pkg::*;
#(
  parameter logic [CAN_ID_W-1:0] address = 11'h025
) (
  input  logic    clk,
  input  logic    RESET,
  input  logic    baud_clk,
  can_rx_if.slave bus
);

  can_state_e     state_q;
  logic [3:0]     idle_cnt_q;
  logic [2:0]     run_cnt_q;
  logic           last_q;
  logic [6:0]     bit_cnt_q;
  logic [6:0]     data_len_q;
  logic [10:0]    id_q;
  logic           rtr_q;
  logic [3:0]     dlc_q;
  logic [63:0]    data_q;
  logic [14:0]    crc_rx_q;

  logic           can_tx_q;
  logic [10:0]    rx_id_q;
  logic           rx_rtr_q;
  logic [3:0]     rx_dlc_q;
  logic [63:0]    rx_data_q;
  logic           rx_valid_q;
  logic           rx_error_q;
  logic [1:0]     err_code_q;

  logic           rx;
  logic           in_region;
  logic           stuff_bit;
  logic           field_bit;
  logic           sof;
  logic           crc_en;
  logic           err_stuff;
  logic           err_crc;
  logic           err_form;
  can_err_e       err_val;
  logic [3:0]     dlc_nxt;
  logic [6:0]     data_len_nxt;
  logic [14:0]    crc_calc;

  can_crc15 u_crc (
    .clk   (clk),
    .RESET (RESET),
    .clr_i (sof),
    .en_i  (crc_en),
    .bit_i (rx),
    .crc_o (crc_calc)
  );

  // CRC_DEL stays in the stuffing region so a stuff bit after the last CRC bit is removed
  always_comb begin
    rx           = bus.CAN_RX;
    in_region    = state_q inside {ST_ID, ST_RTR, ST_IDE, ST_R0, ST_DLC, ST_DATA,
                                   ST_CRC, ST_CRC_DEL};
    stuff_bit    = in_region && (run_cnt_q == 3'd5);
    field_bit    = baud_clk && !stuff_bit;
    sof          = baud_clk && (state_q == ST_IDLE) && !rx;
    crc_en       = sof || (field_bit && (state_q inside {ST_ID, ST_RTR, ST_IDE, ST_R0,
                                                         ST_DLC, ST_DATA}));
    err_stuff    = baud_clk && stuff_bit && (rx == last_q);
    err_crc      = field_bit && (state_q == ST_CRC_DEL) && (crc_rx_q != crc_calc);
    err_form     = field_bit && !rx && !err_crc &&
                   (state_q inside {ST_CRC_DEL, ST_ACK_DEL, ST_EOF});
    err_val      = err_stuff ? ERR_STUFF : (err_crc ? ERR_CRC : ERR_FORM);
    dlc_nxt      = {dlc_q[2:0], rx};
    data_len_nxt = (dlc_nxt > 4'd8) ? 7'd64 : {dlc_nxt, 3'b000};
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_WAIT_IDLE;
      idle_cnt_q <= '0;
      run_cnt_q  <= '0;
      last_q     <= 1'b1;
      bit_cnt_q  <= '0;
      data_len_q <= '0;
      id_q       <= '0;
      rtr_q      <= 1'b0;
      dlc_q      <= '0;
      data_q     <= '0;
      crc_rx_q   <= '0;
      can_tx_q   <= 1'b1;
      rx_id_q    <= '0;
      rx_rtr_q   <= 1'b0;
      rx_dlc_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_error_q <= 1'b0;
      err_code_q <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_error_q <= 1'b0;
      if (err_stuff || err_crc || err_form) begin
        rx_error_q <= 1'b1;
        err_code_q <= err_val;
        can_tx_q   <= 1'b1;
        state_q    <= ST_WAIT_IDLE;
        idle_cnt_q <= '0;
      end else if (baud_clk) begin
        if (stuff_bit) begin
          last_q    <= rx;
          run_cnt_q <= 3'd1;
        end else begin
          if (in_region) begin
            last_q    <= rx;
            run_cnt_q <= (rx == last_q) ? run_cnt_q + 3'd1 : 3'd1;
          end
          case (state_q)
            ST_WAIT_IDLE: begin
              if (!rx) begin
                idle_cnt_q <= '0;
              end else if (idle_cnt_q == 4'(CAN_IDLE_W - 1)) begin
                idle_cnt_q <= '0;
                state_q    <= ST_IDLE;
              end else begin
                idle_cnt_q <= idle_cnt_q + 4'd1;
              end
            end
            ST_IDLE: begin
              if (!rx) begin
                last_q    <= 1'b0;
                run_cnt_q <= 3'd1;
                bit_cnt_q <= '0;
                dlc_q     <= '0;
                data_q    <= '0;
                state_q   <= ST_ID;
              end
            end
            ST_ID: begin
              id_q <= {id_q[9:0], rx};
              if (bit_cnt_q == 7'(CAN_ID_W - 1)) begin
                bit_cnt_q <= '0;
                state_q   <= ST_RTR;
              end else begin
                bit_cnt_q <= bit_cnt_q + 7'd1;
              end
            end
            ST_RTR: begin
              rtr_q   <= rx;
              state_q <= ST_IDE;
            end
            ST_IDE: begin
              if (rx) begin
                idle_cnt_q <= '0;
                state_q    <= ST_WAIT_IDLE;
              end else begin
                state_q <= ST_R0;
              end
            end
            ST_R0: state_q <= ST_DLC;
            ST_DLC: begin
              dlc_q <= dlc_nxt;
              if (bit_cnt_q == 7'(CAN_DLC_W - 1)) begin
                bit_cnt_q  <= '0;
                data_len_q <= data_len_nxt;
                state_q    <= (rtr_q || data_len_nxt == 7'd0) ? ST_CRC : ST_DATA;
              end else begin
                bit_cnt_q <= bit_cnt_q + 7'd1;
              end
            end
            ST_DATA: begin
              data_q[~bit_cnt_q[5:0]] <= rx;
              if (bit_cnt_q == data_len_q - 7'd1) begin
                bit_cnt_q <= '0;
                state_q   <= ST_CRC;
              end else begin
                bit_cnt_q <= bit_cnt_q + 7'd1;
              end
            end
            ST_CRC: begin
              crc_rx_q <= {crc_rx_q[13:0], rx};
              if (bit_cnt_q == 7'(CAN_CRC_W - 1)) begin
                bit_cnt_q <= '0;
                state_q   <= ST_CRC_DEL;
              end else begin
                bit_cnt_q <= bit_cnt_q + 7'd1;
              end
            end
            ST_CRC_DEL: begin
              can_tx_q <= 1'b0;
              state_q  <= ST_ACK_SLOT;
            end
            ST_ACK_SLOT: begin
              can_tx_q <= 1'b1;
              state_q  <= ST_ACK_DEL;
            end
            ST_ACK_DEL: begin
              bit_cnt_q <= '0;
              state_q   <= ST_EOF;
            end
            ST_EOF: begin
              if (bit_cnt_q == 7'(CAN_EOF_W - 1)) begin
                bit_cnt_q <= '0;
                state_q   <= ST_IDLE;
                if (id_q == address) begin
                  rx_valid_q <= 1'b1;
                  rx_id_q    <= id_q;
                  rx_rtr_q   <= rtr_q;
                  rx_dlc_q   <= dlc_q;
                  rx_data_q  <= data_q;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 7'd1;
              end
            end
            default: state_q <= ST_WAIT_IDLE;
          endcase
        end
      end
    end
  end

  assign bus.CAN_TX   = can_tx_q;
  assign bus.rx_id    = rx_id_q;
  assign bus.rx_rtr   = rx_rtr_q;
  assign bus.rx_dlc   = rx_dlc_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_error = rx_error_q;
  assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_can_rx.sv
// Scoreboard bench for can_rx: frames are built bit-by-bit with their own CRC and stuffing.
module tb_can_rx;

  localparam int BAUD_DIV = 4;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
  } exp_t;

  logic clk      = 1'b0;
  logic RESET    = 1'b0;
  logic baud_clk = 1'b0;

  can_rx_if bus();

  can_rx #(.address(11'h025)) dut (
    .clk      (clk),
    .RESET    (RESET),
    .baud_clk (baud_clk),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin : baud_gen
    int bcnt;
    bcnt = 0;
    forever begin
      @(posedge clk);
      #1 baud_clk = (bcnt == BAUD_DIV - 1);
      bcnt = (bcnt + 1) % BAUD_DIV;
    end
  end

  exp_t exp_q[$];
  logic frame_q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   ack_low = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_valid(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                           input logic [63:0] data);
    exp_t e;
    e.is_err = 1'b0; e.code = 2'd0; e.id = id; e.rtr = rtr; e.dlc = dlc; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic exp_err(input logic [1:0] code);
    exp_t e;
    e.is_err = 1'b1; e.code = code; e.id = '0; e.rtr = 1'b0; e.dlc = '0; e.data = '0;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!bus.CAN_TX) ack_low++;
      if (bus.rx_valid || bus.rx_error) begin
        chk("valid_error_exclusive", 64'(bus.rx_valid & bus.rx_error), 64'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 64'({bus.rx_valid, bus.rx_error}), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind_is_error", 64'(bus.rx_error), 64'(e.is_err));
          if (e.is_err) begin
            chk("err_code", 64'(bus.err_code), 64'(e.code));
          end else begin
            chk("rx_id", 64'(bus.rx_id), 64'(e.id));
            chk("rx_rtr", 64'(bus.rx_rtr), 64'(e.rtr));
            chk("rx_dlc", 64'(bus.rx_dlc), 64'(e.dlc));
            chk("rx_data", bus.rx_data, e.data);
          end
        end
      end
    end
  endtask

  task automatic build_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                             input logic [63:0] data, input int crc_flip, input int bad_stuff,
                             input int eof_dom);
    logic        raw[$];
    logic [14:0] crc;
    logic        fb, last, s;
    int          cnt, nbytes, nst;
    raw = {};
    frame_q = {};
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    raw.push_back(rtr);
    raw.push_back(1'b0);
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    nbytes = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int i = 0; i < nbytes * 8; i++) raw.push_back(data[63 - i]);
    crc = '0;
    foreach (raw[i]) begin
      fb  = raw[i] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (fb) crc = crc ^ 15'h4599;
    end
    for (int i = 14; i >= 0; i--) raw.push_back(crc[i] ^ (i == crc_flip));
    last = 1'b1;
    cnt  = 0;
    nst  = 0;
    foreach (raw[i]) begin
      frame_q.push_back(raw[i]);
      if (raw[i] == last) cnt++;
      else begin
        cnt  = 1;
        last = raw[i];
      end
      if (cnt == 5) begin
        s = (nst == bad_stuff) ? last : ~last;
        frame_q.push_back(s);
        nst++;
        last = s;
        cnt  = 1;
      end
    end
    repeat (3) frame_q.push_back(1'b1);
    for (int i = 0; i < 7; i++) frame_q.push_back((i == eof_dom) ? 1'b0 : 1'b1);
  endtask

  task automatic send_bit(input logic b);
    bus.CAN_RX = b;
    @(posedge clk);
    while (!baud_clk) @(posedge clk);
    #2;
  endtask

  task automatic send_frame();
    foreach (frame_q[i]) send_bit(frame_q[i]);
  endtask

  task automatic send_prefix(input int n);
    for (int i = 0; i < n; i++) send_bit(frame_q[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_CAN_TX"},   64'(bus.CAN_TX), 64'd1);
    chk({tag, "_rx_valid"}, 64'(bus.rx_valid), 64'd0);
    chk({tag, "_rx_error"}, 64'(bus.rx_error), 64'd0);
    chk({tag, "_rx_id"},    64'(bus.rx_id), 64'd0);
    chk({tag, "_rx_rtr"},   64'(bus.rx_rtr), 64'd0);
    chk({tag, "_rx_dlc"},   64'(bus.rx_dlc), 64'd0);
    chk({tag, "_rx_data"},  bus.rx_data, 64'd0);
    chk({tag, "_err_code"}, 64'(bus.err_code), 64'd0);
  endtask

  initial begin : stim
    int a0;
    bus.CAN_RX = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #2;
    chk_reset_outputs("reset");
    RESET = 1'b1;
    idle(12);

    // ID 0x025, DLC 4, DE AD BE EF
    a0 = ack_low;
    build_frame(11'h025, 1'b0, 4'd4, 64'hDEADBEEF_00000000, -1, -1, -1);
    exp_valid(11'h025, 1'b0, 4'd4, 64'hDEADBEEF_00000000);
    send_frame();
    chk("ack_frame_a", 64'(ack_low - a0), 64'(BAUD_DIV));
    idle(3);

    // non-matching ID still acknowledged, outputs hold
    a0 = ack_low;
    build_frame(11'h026, 1'b0, 4'd4, 64'hDEADBEEF_00000000, -1, -1, -1);
    send_frame();
    chk("ack_other_id", 64'(ack_low - a0), 64'(BAUD_DIV));
    idle(3);
    chk("hold_rx_id", 64'(bus.rx_id), 64'h025);
    chk("hold_rx_dlc", 64'(bus.rx_dlc), 64'd4);
    chk("hold_rx_data", bus.rx_data, 64'hDEADBEEF_00000000);

    // DLC 0, stuff bits in ID
    a0 = ack_low;
    build_frame(11'h025, 1'b0, 4'd0, 64'd0, -1, -1, -1);
    exp_valid(11'h025, 1'b0, 4'd0, 64'd0);
    send_frame();
    chk("ack_dlc0", 64'(ack_low - a0), 64'(BAUD_DIV));
    idle(3);

    // RTR frame with DLC 2: no data bits, DLC reported raw
    build_frame(11'h025, 1'b1, 4'd2, 64'd0, -1, -1, -1);
    exp_valid(11'h025, 1'b1, 4'd2, 64'd0);
    send_frame();
    idle(3);

    // DLC 12 treated as 8 bytes
    build_frame(11'h025, 1'b0, 4'd12, 64'h0123456789ABCDEF, -1, -1, -1);
    exp_valid(11'h025, 1'b0, 4'd12, 64'h0123456789ABCDEF);
    send_frame();
    idle(3);

    // CRC bit flipped: no ACK, CRC error, then recovery
    a0 = ack_low;
    build_frame(11'h025, 1'b0, 4'd4, 64'hDEADBEEF_00000000, 3, -1, -1);
    exp_err(2'd2);
    send_frame();
    chk("no_ack_crc_err", 64'(ack_low - a0), 64'd0);
    idle(12);
    build_frame(11'h025, 1'b0, 4'd1, 64'h5A00000000000000, -1, -1, -1);
    exp_valid(11'h025, 1'b0, 4'd1, 64'h5A00000000000000);
    send_frame();
    idle(3);

    // second stuff bit of the DLC-0 frame falls inside DLC; make it a sixth equal bit
    a0 = ack_low;
    build_frame(11'h025, 1'b0, 4'd0, 64'd0, -1, 1, -1);
    exp_err(2'd1);
    send_frame();
    chk("no_ack_stuff_err", 64'(ack_low - a0), 64'd0);
    idle(12);

    // dominant EOF bit 3
    a0 = ack_low;
    build_frame(11'h025, 1'b0, 4'd4, 64'hDEADBEEF_00000000, -1, -1, 2);
    exp_err(2'd3);
    send_frame();
    chk("ack_before_form_err", 64'(ack_low - a0), 64'(BAUD_DIV));
    idle(12);
    chk("err_code_held", 64'(bus.err_code), 64'd3);

    // reset mid-DATA, then an SOF too soon after release is ignored
    build_frame(11'h025, 1'b0, 4'd4, 64'hDEADBEEF_00000000, -1, -1, -1);
    send_prefix(35);
    #3 RESET = 1'b0;
    #20;
    chk_reset_outputs("midreset");
    RESET = 1'b1;
    a0 = ack_low;
    idle(5);
    send_frame();
    chk("no_ack_early_sof", 64'(ack_low - a0), 64'd0);
    idle(12);
    exp_valid(11'h025, 1'b0, 4'd4, 64'hDEADBEEF_00000000);
    send_frame();
    idle(3);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
